// File: rtl/sd_slot_arbiter.sv
// -----------------------------------------------------------------------------
// sd_slot_arbiter
//
// Shares the single SD block-transfer channel between three sector requesters
// (slot 0 = floppy drive 1, slot 1 = HDD, slot 2 = floppy drive 2). One slot is
// granted at a time, in round-robin order. The arbiter presents that slot's
// latched rd/wr/LBA request to the host loader. It routes the host ack back
// only to the granted slot, and it muxes that slot's write byte onto the
// shared sd_buff_din path. Runs on the 14.318 MHz pixel clock domain.
//
// Ports
//   clk            core clock (clk_pixel_14_318 at top level)
//   reset          synchronous, active-high reset
//   req_rd         per-slot read request (level, held until that slot's ack)
//   req_wr         per-slot write request (level, held until that slot's ack)
//   req_lba        per-slot LBA, slot n = bits [32n+31:32n]
//   req_buff_din   per-slot write byte, slot n = bits [8n+7:8n]
//   req_ack        per-slot ack, one-hot or zero
//   host_rd        read request to host
//   host_wr        write request to host
//   host_lba       LBA latched at grant time
//   host_slot      index of the granted slot
//   host_ack       host ack, high for the whole 512-byte transfer
//   host_buff_din  write byte from the granted slot, 0 when nothing is granted
//   busy           high while a grant is outstanding
//   timeout_pulse  one-cycle pulse when a grant is abandoned
// -----------------------------------------------------------------------------
module sd_slot_arbiter #(
  parameter int          NUM_SLOTS      = 3,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd14318180
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SLOTS-1:0]   req_rd,
  input  logic [NUM_SLOTS-1:0]   req_wr,
  input  logic [32*NUM_SLOTS-1:0] req_lba,
  input  logic [8*NUM_SLOTS-1:0] req_buff_din,
  output logic [NUM_SLOTS-1:0]   req_ack,
  output logic                   host_rd,
  output logic                   host_wr,
  output logic [31:0]            host_lba,
  output logic [1:0]             host_slot,
  input  logic                   host_ack,
  output logic [7:0]             host_buff_din,
  output logic                   busy,
  output logic                   timeout_pulse
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  rr_ptr;     // first slot examined by the next IDLE scan
  logic        op_wr;      // latched operation: 1 = write, 0 = read
  logic        ack_d;      // host_ack one cycle ago, for edge detection
  logic [23:0] tmo_cnt;    // ISSUE cycles elapsed without an ack rise

  // Modulo-NUM_SLOTS add on the 2-bit slot index. Index 3 is never produced.
  function automatic logic [1:0] slot_add(input logic [1:0] base,
                                          input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'(NUM_SLOTS)) sum = sum - 3'(NUM_SLOTS);
    return sum[1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Per-slot views of the packed request buses
  // ---------------------------------------------------------------------------
  logic [31:0] lba_arr  [NUM_SLOTS];
  logic [7:0]  buff_arr [NUM_SLOTS];

  // NOTE: these arrays are plain wires unpacking the ports, not storage,
  // so they have nothing to reset.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_unpack
    assign lba_arr[g]  = req_lba[32*g +: 32];
    assign buff_arr[g] = req_buff_din[8*g +: 8];
  end

  logic [NUM_SLOTS-1:0] pending;
  assign pending = req_rd | req_wr;

  // ---------------------------------------------------------------------------
  // Round-robin select: first pending slot at rr_ptr, rr_ptr+1, rr_ptr+2
  // ---------------------------------------------------------------------------
  logic       sel_found;
  logic [1:0] sel_slot;
  logic [1:0] cand;

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_slot  = 2'd0;
    cand      = 2'd0;
    for (int off = 0; off < NUM_SLOTS; off++) begin
      cand = slot_add(rr_ptr, off[1:0]);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_slot  = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ISSUE-state events
  // ---------------------------------------------------------------------------
  logic ack_rise;
  logic issue_ack;
  logic issue_tmo;

  // A host_ack already high on entering ISSUE has ack_d=1, so it is not a rise.
  assign ack_rise  = host_ack & ~ack_d;
  assign issue_ack = (state == ST_ISSUE) && ack_rise;
  assign issue_tmo = (state == ST_ISSUE) && !ack_rise &&
                     (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The request comes from the latched op register. It is masked in the cycle
  // that ends ISSUE, so it drops together with the ack rise or the timeout.
  assign host_rd = (state == ST_ISSUE) && !op_wr && !issue_ack && !issue_tmo;
  assign host_wr = (state == ST_ISSUE) &&  op_wr && !issue_ack && !issue_tmo;

  assign busy = (state != ST_IDLE);

  // A reset cycle never reports an abandoned grant.
  assign timeout_pulse = issue_tmo && !reset;

  // The ack is a combinational pass-through, so the requester sees it fall in
  // the same cycle as the host. The rise cycle in ISSUE is routed as well.
  always_comb begin
    req_ack = '0;
    if (((state == ST_XFER) && host_ack) || issue_ack)
      req_ack[host_slot] = 1'b1;
  end

  assign host_buff_din = busy ? buff_arr[host_slot] : 8'h00;

  // ---------------------------------------------------------------------------
  // State, pointer and latched request
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and the ordering of the statements
  // below does not matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= 2'd0;
      op_wr     <= 1'b0;
      ack_d     <= 1'b0;
      tmo_cnt   <= 24'd0;
      host_slot <= 2'd0;
      host_lba  <= 32'd0;
    end else begin
      ack_d <= host_ack;
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            // Write wins over read. A coincident read stays pending for a
            // later grant because the requester holds it.
            host_slot <= sel_slot;
            host_lba  <= lba_arr[sel_slot];
            op_wr     <= req_wr[sel_slot];
            tmo_cnt   <= 24'd0;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // Dropping the request here does not cancel the grant. The host
          // may still complete the transfer.
          if (issue_ack) begin
            state <= ST_XFER;
          end else if (issue_tmo) begin
            rr_ptr <= slot_add(host_slot, 2'd1);
            state  <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end

        ST_XFER: begin
          if (!host_ack) begin
            rr_ptr <= slot_add(host_slot, 2'd1);
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_slot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_slot_arbiter
//
// Directed bench for sd_slot_arbiter with TIMEOUT_CYCLES = 16. Stimulus pushes
// the expected grant (slot, LBA, op) into a scoreboard queue before raising a
// request. A monitor pops an entry on every rising edge of host_rd|host_wr and
// compares. Timing details (ack routing, write-data mux, timeout cycle, reset
// behaviour) are checked inline against hand-computed values.
// Inputs are driven 1 time unit after posedge. Outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_sd_slot_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_rd;
  logic [2:0]  req_wr;
  logic [95:0] req_lba;
  logic [23:0] req_buff_din;
  logic [2:0]  req_ack;
  logic        host_rd;
  logic        host_wr;
  logic [31:0] host_lba;
  logic [1:0]  host_slot;
  logic        host_ack;
  logic [7:0]  host_buff_din;
  logic        busy;
  logic        timeout_pulse;

  sd_slot_arbiter #(
    .NUM_SLOTS      (3),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_rd        (req_rd),
    .req_wr        (req_wr),
    .req_lba       (req_lba),
    .req_buff_din  (req_buff_din),
    .req_ack       (req_ack),
    .host_rd       (host_rd),
    .host_wr       (host_wr),
    .host_lba      (host_lba),
    .host_slot     (host_slot),
    .host_ack      (host_ack),
    .host_buff_din (host_buff_din),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  slot;
    logic [31:0] lba;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] slot, input logic [31:0] lba,
                      input logic wr);
    exp_t e;
    e.slot = slot;
    e.lba  = lba;
    e.wr   = wr;
    sb.push_back(e);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lba(input int n, input logic [31:0] v);
    req_lba[32*n +: 32] = v;
  endtask

  task automatic set_buff(input int n, input logic [7:0] v);
    req_buff_din[8*n +: 8] = v;
  endtask

  // Wait (bounded) for a request strobe. On return we sit at the negedge of
  // the first ISSUE cycle. waited = number of negedges sampled before it.
  task automatic wait_strobe(output int waited);
    bit seen;
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (host_rd || host_wr) seen = 1'b1;
      else waited++;
    end
    check("strobe_seen", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req_rd   = '0;
    req_wr   = '0;
    host_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: one grant per rising edge of the request strobe.
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if ((host_rd || host_wr) && !prev_strobe) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", 32'(host_slot), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("grant_slot", 32'(host_slot), 32'(e.slot));
        check("grant_lba",  host_lba, e.lba);
        check("grant_wr",   32'(host_wr), 32'(e.wr));
        check("grant_rd",   32'(host_rd), 32'(!e.wr));
      end
    end
    prev_strobe = host_rd || host_wr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int ok_cnt;
    int pulse_at;
    logic rd_at_pulse;

    reset        = 1'b1;
    req_rd       = '0;
    req_wr       = '0;
    req_lba      = '0;
    req_buff_din = '0;
    host_ack     = 1'b0;

    // ---------------- reset state ----------------
    do_reset();
    @(negedge clk);
    check("rst_host_rd",   32'(host_rd), 32'd0);
    check("rst_host_wr",   32'(host_wr), 32'd0);
    check("rst_req_ack",   32'(req_ack), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_timeout",   32'(timeout_pulse), 32'd0);
    check("rst_host_slot", 32'(host_slot), 32'd0);
    check("rst_host_lba",  host_lba, 32'd0);
    check("rst_buff_din",  32'(host_buff_din), 32'd0);

    // ---------------- single slot read, 512-cycle transfer ----------------
    step();
    set_lba(1, 32'h1234);
    push(2'd1, 32'h1234, 1'b0);
    req_rd = 3'b010;
    step();                                  // IDLE select edge
    @(negedge clk);
    check("t1_rd_latency", 32'(host_rd), 32'd1);
    check("t1_busy",       32'(busy), 32'd1);
    step();
    set_lba(1, 32'hFFFF);                    // ignored mid-grant
    step();
    host_ack = 1'b1;
    ok_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (req_ack == 3'b010 && !host_rd && !host_wr &&
          host_lba == 32'h1234 && host_slot == 2'd1 && busy)
        ok_cnt++;
      step();
      if (i == 0) req_rd = 3'b000;           // requester drops on its ack
    end
    host_ack = 1'b0;
    check("t1_ack_window", 32'(ok_cnt), 32'd512);
    @(negedge clk);
    check("t1_ack_fall", 32'(req_ack), 32'd0);
    check("t1_busy_hold", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    check("t1_busy_drop", 32'(busy), 32'd0);

    // ---------------- fairness: all three request continuously ----------------
    do_reset();
    set_lba(0, 32'h100);
    set_lba(1, 32'h101);
    set_lba(2, 32'h102);
    for (int k = 0; k < 6; k++) push(2'(k % 3), 32'h100 + 32'(k % 3), 1'b0);
    req_rd = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_strobe(w);
      if (k > 0) check("t2_turnaround", 32'(w), 32'd2);
      step();
      host_ack = 1'b1;
      for (int j = 0; j < 10; j++) step();
      host_ack = 1'b0;
      if (k == 5) req_rd = 3'b000;
    end
    step();
    step();

    // ---------------- rd+wr on slot 2: write first, then read ----------------
    do_reset();
    set_lba(2, 32'h2000);
    set_buff(0, 8'h11);
    set_buff(1, 8'h22);
    set_buff(2, 8'hA5);
    push(2'd2, 32'h2000, 1'b1);
    req_rd = 3'b100;
    req_wr = 3'b100;
    wait_strobe(w);
    step();
    host_ack = 1'b1;
    step();                                  // now in XFER
    req_wr = 3'b000;                         // rd stays pending
    @(negedge clk);
    check("t3_wdata",   32'(host_buff_din), 32'hA5);
    check("t3_req_ack", 32'(req_ack), 32'b100);
    step();
    set_buff(2, 8'h3C);
    @(negedge clk);
    check("t3_wdata_live", 32'(host_buff_din), 32'h3C);
    push(2'd2, 32'h2000, 1'b0);
    step();
    host_ack = 1'b0;
    wait_strobe(w);
    step();
    host_ack = 1'b1;
    step();
    req_rd = 3'b000;
    step();
    host_ack = 1'b0;
    step();
    step();
    @(negedge clk);
    check("t3_buff_idle", 32'(host_buff_din), 32'd0);
    check("t3_busy_idle", 32'(busy), 32'd0);

    // ---------------- timeout on slot 0, slot 1 next ----------------
    do_reset();
    set_lba(0, 32'h40);
    set_lba(1, 32'h41);
    push(2'd0, 32'h40, 1'b0);
    push(2'd1, 32'h41, 1'b0);
    req_rd = 3'b011;
    wait_strobe(w);                          // ISSUE cycle 1
    pulse_at    = timeout_pulse ? 1 : 0;
    rd_at_pulse = host_rd;
    for (int c = 2; c <= 20 && pulse_at == 0; c++) begin
      @(negedge clk);
      if (timeout_pulse) begin
        pulse_at    = c;
        rd_at_pulse = host_rd;
      end
    end
    check("t4_pulse_cycle", 32'(pulse_at), 32'd16);
    check("t4_rd_at_pulse", 32'(rd_at_pulse), 32'd0);
    @(negedge clk);
    check("t4_pulse_width", 32'(timeout_pulse), 32'd0);
    check("t4_busy_idle",   32'(busy), 32'd0);
    wait_strobe(w);
    check("t4_regrant_wait", 32'(w), 32'd0);
    step();
    host_ack = 1'b1;
    step();
    step();
    host_ack = 1'b0;
    req_rd   = 3'b000;
    step();
    step();

    // ---------------- reset during XFER ----------------
    do_reset();
    set_lba(0, 32'h50);
    set_lba(1, 32'h51);
    push(2'd0, 32'h50, 1'b0);
    req_rd = 3'b001;
    wait_strobe(w);
    step();
    host_ack = 1'b1;
    step();
    req_rd = 3'b010;                         // slot 0 done, slot 1 requests
    push(2'd1, 32'h51, 1'b0);
    step();
    host_ack = 1'b0;
    wait_strobe(w);                          // slot 1 granted, rr_ptr now 1
    step();
    host_ack = 1'b1;
    step();
    @(negedge clk);
    check("t5_ack_before", 32'(req_ack), 32'b010);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("t5_req_ack", 32'(req_ack), 32'd0);
    check("t5_host_rd", 32'(host_rd), 32'd0);
    check("t5_host_wr", 32'(host_wr), 32'd0);
    check("t5_busy",    32'(busy), 32'd0);
    check("t5_timeout", 32'(timeout_pulse), 32'd0);
    step();
    reset    = 1'b0;
    host_ack = 1'b0;
    push(2'd0, 32'h50, 1'b0);                // rr_ptr back to 0
    req_rd = 3'b111;
    wait_strobe(w);
    step();
    host_ack = 1'b1;
    step();
    req_rd = 3'b000;
    step();
    host_ack = 1'b0;
    step();
    step();

    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
